// File: rtl/af_output_packer.sv
// Output end of the af_cluster stream: requantizes each activation to an unsigned lane,
// packs ELEMS_PER_WORD lanes per word and hands words downstream, with partial-word flush.
module af_output_packer #(
    parameter int unsigned DATA_BITWIDTH  = 20,
    parameter int unsigned OUT_BITWIDTH   = 8,
    parameter int unsigned ELEMS_PER_WORD = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [$clog2(DATA_BITWIDTH):0]         shift_i,
    input  logic                                   flush_i,
    input  logic [DATA_BITWIDTH-1:0]               data_i,
    input  logic                                   enable_i,
    output logic                                   ready_o,
    output logic [OUT_BITWIDTH*ELEMS_PER_WORD-1:0] data_o,
    output logic [$clog2(ELEMS_PER_WORD):0]        lanes_o,
    output logic                                   enable_o,
    input  logic                                   ready_i
);

    localparam int unsigned SW = $clog2(DATA_BITWIDTH) + 1;
    localparam int unsigned CW = $clog2(ELEMS_PER_WORD);
    localparam int unsigned LW = CW + 1;
    localparam int unsigned WW = OUT_BITWIDTH * ELEMS_PER_WORD;
    localparam logic [CW-1:0] LAST_LANE = CW'(ELEMS_PER_WORD - 1);
    localparam logic [DATA_BITWIDTH:0] ONE = 1;

    typedef enum logic {
        OUT_EMPTY,
        OUT_HOLD
    } out_state_t;

    out_state_t                  out_state;
    logic [CW-1:0]               fill_cnt;
    logic [WW-1:0]               fill_reg;
    logic                        flush_pending;

    logic [OUT_BITWIDTH-1:0]     lane_val;
    logic [WW-1:0]               merged;
    logic [LW-1:0]               lanes_next;
    logic                        in_fire;
    logic                        out_free;
    logic                        word_done;
    logic                        flush_act;
    logic                        emit_partial;

    // Round-half-up, shift right, clamp; negatives and oversize shifts give zero.
    function automatic logic [OUT_BITWIDTH-1:0] requant(
        input logic [DATA_BITWIDTH-1:0] x,
        input logic [SW-1:0]            s
    );
        logic [DATA_BITWIDTH:0]  rnd;
        logic [DATA_BITWIDTH:0]  sum;
        logic [DATA_BITWIDTH:0]  r;
        logic [OUT_BITWIDTH-1:0] q;
        rnd = '0;
        sum = '0;
        r   = '0;
        q   = '0;
        if (!x[DATA_BITWIDTH-1] && (s < SW'(DATA_BITWIDTH))) begin
            if (s != '0) begin
                rnd = ONE << (s - SW'(1));
            end
            sum = {1'b0, x} + rnd;
            r   = sum >> s;
            q   = (|r[DATA_BITWIDTH:OUT_BITWIDTH]) ? '1 : r[OUT_BITWIDTH-1:0];
        end
        return q;
    endfunction

    assign enable_o = (out_state == OUT_HOLD);
    assign out_free = !enable_o || ready_i;
    assign ready_o  = !flush_pending && ((fill_cnt != LAST_LANE) || out_free);
    assign in_fire  = enable_i && ready_o;
    assign lane_val = requant(data_i, shift_i);

    assign word_done    = in_fire && (fill_cnt == LAST_LANE);
    // A flush that coincides with word completion has nothing left to emit.
    assign flush_act    = flush_i && !flush_pending && !word_done &&
                          ((fill_cnt != '0) || in_fire);
    assign emit_partial = (flush_act || flush_pending) && out_free;
    assign lanes_next   = LW'(fill_cnt) + LW'(in_fire);

    always_comb begin
        merged = fill_reg;
        for (int unsigned l = 0; l < ELEMS_PER_WORD; l++) begin
            if (in_fire && (fill_cnt == CW'(l))) begin
                merged[l*OUT_BITWIDTH +: OUT_BITWIDTH] = lane_val;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_state     <= OUT_EMPTY;
            data_o        <= '0;
            lanes_o       <= '0;
            fill_cnt      <= '0;
            fill_reg      <= '0;
            flush_pending <= 1'b0;
        end else if (word_done || emit_partial) begin
            // Fill register is cleared on every move so unused lanes of a flushed word read 0.
            out_state     <= OUT_HOLD;
            data_o        <= merged;
            lanes_o       <= word_done ? LW'(ELEMS_PER_WORD) : lanes_next;
            fill_cnt      <= '0;
            fill_reg      <= '0;
            flush_pending <= 1'b0;
        end else begin
            if ((out_state == OUT_HOLD) && ready_i) begin
                out_state <= OUT_EMPTY;
            end
            if (in_fire) begin
                fill_reg <= merged;
                fill_cnt <= fill_cnt + CW'(1);
            end
            if (flush_act) begin
                flush_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_af_output_packer.sv
// Directed bench for af_output_packer: table of full-word requant vectors plus
// hand-written sequences for backpressure, flush and reset corner cases.
module tb_af_output_packer;

    logic        clk;
    logic        rst_i;
    logic [5:0]  shift_i;
    logic        flush_i;
    logic [19:0] data_i;
    logic        enable_i;
    logic        ready_o;
    logic [31:0] data_o;
    logic [2:0]  lanes_o;
    logic        enable_o;
    logic        ready_i;

    int checks = 0;
    int errors = 0;

    af_output_packer #(
        .DATA_BITWIDTH (20),
        .OUT_BITWIDTH  (8),
        .ELEMS_PER_WORD(4)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .shift_i (shift_i),
        .flush_i (flush_i),
        .data_i  (data_i),
        .enable_i(enable_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .lanes_o (lanes_o),
        .enable_o(enable_o),
        .ready_i (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]       shift;
        logic [3:0][19:0] d;      // index 0 = lane 0
        logic [31:0]      exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic push(input logic [19:0] d, input logic [5:0] s);
        int n = 0;
        enable_i = 1'b1;
        data_i   = d;
        shift_i  = s;
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: ready_o stayed %b, required 1", ready_o);
        end
        @(negedge clk);
        enable_i = 1'b0;
    endtask

    task automatic flush_pulse();
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{shift: 6'd0,  d: {20'd256, 20'd255, 20'd100, 20'd0},             exp: 32'hFFFF_6400};
        vecs[1] = '{shift: 6'd4,  d: {20'd524287, 20'd23, 20'd24, 20'hFFFFF},        exp: 32'hFF01_0200};
        vecs[2] = '{shift: 6'd1,  d: {20'd510, 20'd3, 20'd2, 20'd1},                 exp: 32'hFF02_0101};
        vecs[3] = '{shift: 6'd19, d: {20'h80000, 20'd262143, 20'd262144, 20'd524287}, exp: 32'h0000_0101};
        vecs[4] = '{shift: 6'd20, d: {20'd1, 20'h7FFFF, 20'd100, 20'd524287},        exp: 32'h0000_0000};
        vecs[5] = '{shift: 6'd63, d: {20'd1, 20'd2, 20'd3, 20'd524287},              exp: 32'h0000_0000};
        vecs[6] = '{shift: 6'd8,  d: {20'd65535, 20'd65536, 20'd32639, 20'd32640},   exp: 32'hFFFF_7F80};
        vecs[7] = '{shift: 6'd0,  d: {20'h80001, 20'd1, 20'd254, 20'd255},           exp: 32'h0001_FEFF};

        rst_i    = 1'b1;
        shift_i  = '0;
        flush_i  = 1'b0;
        data_i   = '0;
        enable_i = 1'b0;
        ready_i  = 1'b0;
        #1;
        chk("reset_enable_o", 32'(enable_o), 32'd0);
        chk("reset_ready_o",  32'(ready_o),  32'd1);
        chk("reset_data_o",   data_o,        32'd0);
        chk("reset_lanes_o",  32'(lanes_o),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;

        // Full-word requant table
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int l = 0; l < 4; l++) begin
                push(vecs[i].d[l], vecs[i].shift);
                if (l == 2) chk($sformatf("vec%0d_not_early", i), 32'(enable_o && lanes_o == 3'd4 && data_o == vecs[i].exp && i != 0 && vecs[i-1].exp != vecs[i].exp), 32'd0);
            end
            chk($sformatf("vec%0d_enable", i), 32'(enable_o), 32'd1);
            chk($sformatf("vec%0d_data", i),   data_o,        vecs[i].exp);
            chk($sformatf("vec%0d_lanes", i),  32'(lanes_o),  32'd4);
        end
        @(negedge clk);
        chk("table_drained", 32'(enable_o), 32'd0);

        // Backpressure: 8 elements, second word replaces first with no bubble
        ready_i = 1'b0;
        for (int v = 1; v <= 7; v++) push(20'(v), 6'd0);
        chk("bp_ready_low",  32'(ready_o),  32'd0);
        chk("bp_word1_hold", 32'(enable_o), 32'd1);
        chk("bp_word1_data", data_o,        32'h0403_0201);
        @(negedge clk);
        chk("bp_word1_stable", data_o, 32'h0403_0201);
        enable_i = 1'b1;
        data_i   = 20'd8;
        ready_i  = 1'b1;
        #1;
        chk("bp_ready_with_ready_i", 32'(ready_o), 32'd1);
        @(negedge clk);
        enable_i = 1'b0;
        ready_i  = 1'b0;
        chk("bp_word2_enable", 32'(enable_o), 32'd1);
        chk("bp_word2_data",   data_o,        32'h0807_0605);
        chk("bp_word2_lanes",  32'(lanes_o),  32'd4);
        @(negedge clk);
        chk("bp_word2_stable", data_o, 32'h0807_0605);
        ready_i = 1'b1;
        @(negedge clk);
        chk("bp_drained", 32'(enable_o), 32'd0);

        // Flush of a partial word
        push(20'd5, 6'd0);
        push(20'd7, 6'd0);
        chk("flush_not_yet", 32'(enable_o), 32'd0);
        flush_pulse();
        chk("flush_enable", 32'(enable_o), 32'd1);
        chk("flush_data",   data_o,        32'h0000_0705);
        chk("flush_lanes",  32'(lanes_o),  32'd2);
        @(negedge clk);
        chk("flush_drained", 32'(enable_o), 32'd0);
        flush_pulse();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("flush_empty_ignored%0d", c), 32'(enable_o), 32'd0);
            @(negedge clk);
        end

        // Flush together with an accept includes that element
        push(20'd3, 6'd0);
        enable_i = 1'b1;
        data_i   = 20'd9;
        flush_i  = 1'b1;
        @(negedge clk);
        enable_i = 1'b0;
        flush_i  = 1'b0;
        chk("flush_accept_data",  data_o,       32'h0000_0903);
        chk("flush_accept_lanes", 32'(lanes_o), 32'd2);
        @(negedge clk);

        // Flush while a word is held
        ready_i = 1'b0;
        for (int v = 10; v <= 13; v++) push(20'(v), 6'd0);
        push(20'h21, 6'd0);
        flush_pulse();
        chk("pend_ready_low", 32'(ready_o), 32'd0);
        chk("pend_held_data", data_o,       32'h0D0C_0B0A);
        flush_pulse();
        @(negedge clk);
        chk("pend_ready_still_low", 32'(ready_o), 32'd0);
        ready_i = 1'b1;
        @(negedge clk);
        chk("pend_enable", 32'(enable_o), 32'd1);
        chk("pend_data",   data_o,        32'h0000_0021);
        chk("pend_lanes",  32'(lanes_o),  32'd1);
        chk("pend_ready",  32'(ready_o),  32'd1);
        @(negedge clk);
        chk("pend_drained", 32'(enable_o), 32'd0);
        @(negedge clk);
        chk("pend_no_extra", 32'(enable_o), 32'd0);

        // Reset mid-stream discards held and partial words
        ready_i = 1'b0;
        for (int v = 1; v <= 5; v++) push(20'(v), 6'd0);
        #2 rst_i = 1'b1;
        #1;
        chk("midrst_enable_o", 32'(enable_o), 32'd0);
        chk("midrst_ready_o",  32'(ready_o),  32'd1);
        chk("midrst_data_o",   data_o,        32'd0);
        @(negedge clk);
        rst_i   = 1'b0;
        ready_i = 1'b1;
        chk("midrst_idle", 32'(enable_o), 32'd0);
        push(20'h11, 6'd0);
        push(20'h22, 6'd0);
        flush_pulse();
        chk("midrst_flush_data",  data_o,       32'h0000_2211);
        chk("midrst_flush_lanes", 32'(lanes_o), 32'd2);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
